debounce_scan_ctrl: RTL and testbench

//   Shared debounce controller for N_BTN push-button inputs. One prescaler

---
 rtl/debounce_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_ctrl.sv
// Shared-datapath debounce controller: one prescaler tick starts a scan that
// visits one button channel per clock, accepting a new level after STABLE samples.
module debounce_scan_ctrl #(
    parameter int N_BTN  = 4,
    parameter int DIV    = 50000,
    parameter int STABLE = 4
) (
    input  logic             CK_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N_BTN-1:0] entrada_i,
    output logic [N_BTN-1:0] saida_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int PC_W  = (DIV > 1)    ? $clog2(DIV)    : 1;
    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int IDX_W = (N_BTN > 1)  ? $clog2(N_BTN)  : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BTN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic             tick;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [N_BTN-1:0] saida_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic             overrun_q;

    logic             samp;
    logic             differ;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_d;

    // Two-flop synchronizer; only the second stage feeds the scan datapath.
    always_ff @(posedge CK_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= entrada_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        pc_d = pc_q;
        tick = 1'b0;
        if (en_i) begin
            if (pc_q == PC_LAST) begin
                pc_d = '0;
                tick = 1'b1;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge CK_i or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Shared compare/count path for whichever channel idx_q points at.
    always_comb begin
        samp     = sync2_q[idx_q];
        differ   = (samp != saida_q[idx_q]);
        cnt_cur  = cnt_q[idx_q];
        accept_d = differ && (cnt_cur == CNT_LAST);
        cnt_d    = '0;
        if (differ && !accept_d) begin
            cnt_d = cnt_cur + CNT_W'(1);
        end
    end

    always_ff @(posedge CK_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            saida_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            press_q   <= '0;
            release_q <= '0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    cnt_q[idx_q] <= cnt_d;
                    if (accept_d) begin
                        saida_q[idx_q]   <= samp;
                        press_q[idx_q]   <= samp;
                        release_q[idx_q] <= ~samp;
                    end
                    // A tick landing on any scan cycle, including the last, is dropped.
                    if (tick) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    assign saida_o   = saida_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign busy_o    = (state_q == SCAN);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: two instances (DIV=8 and DIV=4) share stimulus
// and are checked each cycle against a sample-history model plus literal points.
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int ST = 4;

    logic         CK = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] entrada;
    logic [N-1:0] saida [2];
    logic [N-1:0] press [2];
    logic [N-1:0] rls   [2];
    logic         busy  [2];
    logic         ovr   [2];

    debounce_scan_ctrl #(.N_BTN(N), .DIV(8), .STABLE(ST)) dut0 (
        .CK_i(CK), .rst_n(rst_n), .en_i(en), .entrada_i(entrada),
        .saida_o(saida[0]), .press_o(press[0]), .release_o(rls[0]),
        .busy_o(busy[0]), .overrun_o(ovr[0])
    );

    debounce_scan_ctrl #(.N_BTN(N), .DIV(4), .STABLE(ST)) dut1 (
        .CK_i(CK), .rst_n(rst_n), .en_i(en), .entrada_i(entrada),
        .saida_o(saida[1]), .press_o(press[1]), .release_o(rls[1]),
        .busy_o(busy[1]), .overrun_o(ovr[1])
    );

    always #5 CK = ~CK;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    // Model state: edges since reset release, pin samples two edges back,
    // per-unit prescaler phase, remaining scan slots, runs of differing samples.
    int           edge_n;
    logic [N-1:0] e_d1, e_d2;
    int           m_pc   [2];
    int           m_left [2];
    int           m_run  [2][N];
    logic [N-1:0] m_lvl  [2];
    logic [N-1:0] m_prs  [2];
    logic [N-1:0] m_rls  [2];
    logic         m_ovr  [2];

    task automatic model_clear();
        edge_n = 0;
        e_d1   = '0;
        e_d2   = '0;
        for (int u = 0; u < 2; u++) begin
            m_pc[u]   = 0;
            m_left[u] = 0;
            m_lvl[u]  = '0;
            m_prs[u]  = '0;
            m_rls[u]  = '0;
            m_ovr[u]  = 1'b0;
            for (int c = 0; c < N; c++) m_run[u][c] = 0;
        end
    endtask

    initial begin : model
        int ch;
        bit tk;
        model_clear();
        forever begin
            @(posedge CK or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                edge_n++;
                for (int u = 0; u < 2; u++) begin
                    tk = en && (m_pc[u] == div_of(u) - 1);
                    if (en) m_pc[u] = (m_pc[u] + 1) % div_of(u);
                    m_prs[u] = '0;
                    m_rls[u] = '0;
                    if (m_left[u] > 0) begin
                        ch = N - m_left[u];
                        if (e_d2[ch] == m_lvl[u][ch]) begin
                            m_run[u][ch] = 0;
                        end else begin
                            m_run[u][ch]++;
                            if (m_run[u][ch] == ST) begin
                                m_lvl[u][ch] = e_d2[ch];
                                m_run[u][ch] = 0;
                                if (e_d2[ch]) m_prs[u][ch] = 1'b1;
                                else          m_rls[u][ch] = 1'b1;
                            end
                        end
                        m_left[u]--;
                        if (tk) m_ovr[u] = 1'b1;
                    end else if (tk) begin
                        m_left[u] = N;
                    end
                end
                e_d2 = e_d1;
                e_d1 = entrada;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge CK);
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d saida", u),   32'(saida[u]), 32'(m_lvl[u]));
                check($sformatf("u%0d press", u),   32'(press[u]), 32'(m_prs[u]));
                check($sformatf("u%0d release", u), 32'(rls[u]),   32'(m_rls[u]));
                check($sformatf("u%0d busy", u),    32'(busy[u]),  32'(m_left[u] > 0));
                check($sformatf("u%0d overrun", u), 32'(ovr[u]),   32'(m_ovr[u]));
                check($sformatf("u%0d press onehot", u), 32'($onehot0(press[u])), 32'h1);
            end
        end
    end

    task automatic goto_edge(input int n);
        while (edge_n < n) begin
            @(posedge CK);
            #1;
        end
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst_n   = 1'b0;
        en      = 1'b1;
        entrada = 4'h4;
        repeat (3) @(posedge CK);
        #2;
        check("reset saida", 32'(saida[0]), 32'h0);
        check("reset busy",  32'(busy[0]),  32'h0);
        rst_n = 1'b1;

        // Clean press on channel 2: scans of ch2 at edges 11,19,27,35.
        goto_edge(34);
        check("t2 saida before", 32'(saida[0]), 32'h0);
        goto_edge(35);
        check("t2 saida accept", 32'(saida[0]), 32'h4);
        check("t2 press pulse",  32'(press[0]), 32'h4);
        check("t2 release none", 32'(rls[0]),   32'h0);
        goto_edge(36);
        check("t2 press cleared", 32'(press[0]), 32'h0);
        entrada[1] = 1'b1;

        // Bounce on channel 1: samples 1,1,1,0 then steady 1.
        goto_edge(60);
        entrada[1] = 1'b0;
        goto_edge(66);
        check("t3 no accept on bounce", 32'(saida[0]), 32'h4);
        goto_edge(68);
        entrada[1] = 1'b1;
        goto_edge(97);
        check("t3 saida before", 32'(saida[0]), 32'h4);
        goto_edge(98);
        check("t3 saida accept", 32'(saida[0]), 32'h6);
        check("t3 press pulse",  32'(press[0]), 32'h2);

        // Release on channel 0 after first raising it.
        goto_edge(100);
        entrada[0] = 1'b1;
        goto_edge(129);
        check("t4 saida raised", 32'(saida[0]), 32'h7);
        check("t4 press ch0",    32'(press[0]), 32'h1);
        goto_edge(130);
        entrada[0] = 1'b0;
        goto_edge(161);
        check("t4 saida fell",   32'(saida[0]), 32'h6);
        check("t4 release ch0",  32'(rls[0]),   32'h1);
        check("t4 press none",   32'(press[0]), 32'h0);
        goto_edge(162);
        check("t4 release cleared", 32'(rls[0]), 32'h0);
        entrada = 4'h0;
        goto_edge(195);
        check("t5 all low", 32'(saida[0]), 32'h0);

        // All four pins rise together.
        goto_edge(196);
        entrada = 4'hF;
        goto_edge(225);
        check("t5 press 0", 32'(press[0]), 32'h1);
        check("t5 saida 0", 32'(saida[0]), 32'h1);
        goto_edge(226);
        check("t5 press 1", 32'(press[0]), 32'h2);
        check("t5 saida 1", 32'(saida[0]), 32'h3);
        goto_edge(227);
        check("t5 press 2", 32'(press[0]), 32'h4);
        check("t5 saida 2", 32'(saida[0]), 32'h7);
        goto_edge(228);
        check("t5 press 3", 32'(press[0]), 32'h8);
        check("t5 saida 3", 32'(saida[0]), 32'hF);
        goto_edge(229);
        check("t5 press done", 32'(press[0]), 32'h0);

        // Asynchronous reset in the middle of a scan.
        goto_edge(234);
        check("t1 busy mid-scan",  32'(busy[0]), 32'h1);
        check("t6 overrun dut1",   32'(ovr[1]),  32'h1);
        check("t6 no overrun dut0", 32'(ovr[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("t1 u%0d saida", u),   32'(saida[u]), 32'h0);
            check($sformatf("t1 u%0d press", u),   32'(press[u]), 32'h0);
            check($sformatf("t1 u%0d release", u), 32'(rls[u]),   32'h0);
            check($sformatf("t1 u%0d busy", u),    32'(busy[u]),  32'h0);
            check($sformatf("t1 u%0d overrun", u), 32'(ovr[u]),   32'h0);
        end
        @(posedge CK);
        @(posedge CK);
        #2;
        rst_n = 1'b1;

        // DIV=4: tick at edge 4 starts a scan whose last cycle meets tick at edge 8.
        goto_edge(7);
        check("t6 overrun before", 32'(ovr[1]), 32'h0);
        goto_edge(8);
        check("t6 overrun set",    32'(ovr[1]), 32'h1);
        goto_edge(10);
        check("t6 dut0 scanning",  32'(busy[0]), 32'h1);
        en = 1'b0;
        goto_edge(12);
        check("t6 dut0 scan done", 32'(busy[0]), 32'h0);
        goto_edge(50);
        check("t6 dut0 idle",      32'(busy[0]), 32'h0);
        check("t6 dut1 idle",      32'(busy[1]), 32'h0);
        check("t6 overrun sticky", 32'(ovr[1]),  32'h1);
        check("t6 dut0 no overrun", 32'(ovr[0]), 32'h0);
        en = 1'b1;
        goto_edge(70);
        check("t6 overrun still set", 32'(ovr[1]), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
